glitch_sequencer: RTL and testbench
===================================

Name: glitch_sequencer

Overview:
- Timing engine for the glitcher. It consumes the configuration registers written over UART (delay, width, pulse count, pulse spacing, enable).
- On a rising edge of an external target trigger, it waits a programmed delay. It then emits a train of glitch pulses with programmed width, count and spacing.
- Sits between the UART command handler and the glitch output pin driver.

Parameters:
- SYNC_STAGES, 2, number of flops in the trigger_i synchronizer (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- trigger_i  in  1  asynchronous target trigger; a rising edge starts a sequence.
- arm_i  in  1  sequencer enable (the pulse_en register); low means triggers are ignored and any running sequence aborts.
- delay_i  in  16  cycles from detected trigger to first pulse.
- width_i  in  8  high cycles per pulse.
- num_pulses_i  in  8  pulses per sequence.
- pulse_spacing_i  in  16  low cycles between consecutive pulses.
- glitch_o  out  1  registered glitch pulse output.
- busy_o  out  1  high while a sequence is in progress.
- done_o  out  1  one-cycle strobe when a sequence completes normally.

Behaviour:
- Reset (async assert, sync release): glitch_o=0, busy_o=0, done_o=0, synchronizer and edge flops cleared, state=IDLE, counters 0.
- Trigger path:
  - SYNC_STAGES-flop synchronizer, then a previous-value register.
  - rise = sync & ~prev.
  - Only rising edges start a sequence; a held-high trigger does not retrigger.
- Snapshot: on acceptance, delay/width/num_pulses/spacing are latched internally. Input changes mid-sequence have no effect until the next sequence.
- Zero handling:
  - width=0 or num_pulses=0: the trigger is accepted but no pulse is emitted. done_o is strobed on the acceptance edge, busy_o never rises, and state stays IDLE.
  - spacing=0 is treated as 1 low cycle.
- States: IDLE, DELAY, PULSE, GAP. A 16-bit shared down-counter is used; an 8-bit pulse counter counts remaining pulses.
- IDLE:
  - Acts when arm_i & rise.
  - If D=0, go to PULSE (glitch_o<=1, cnt<=W-1).
  - Otherwise go to DELAY (cnt<=D-1).
  - busy_o<=1.
- DELAY: decrement cnt; when cnt==0, go to PULSE, glitch_o<=1, cnt<=W-1.
- PULSE:
  - Decrement cnt; when cnt==0, glitch_o<=0.
  - If pulses remain, go to GAP with cnt<=max(S,1)-1.
  - Otherwise go to IDLE with busy_o<=0 and done_o<=1 for one cycle.
- GAP: decrement cnt; when cnt==0, go to PULSE, glitch_o<=1, cnt<=W-1.
- Timing: let E0 be the first clk edge at which trigger_i is sampled high (after being low).
  - glitch_o rises after edge E0+SYNC_STAGES+D.
  - Each pulse is high exactly W cycles and low exactly max(S,1) cycles between pulses.
  - busy_o rises after edge E0+SYNC_STAGES.
  - busy_o falls, and done_o pulses, on the same edge as the final glitch_o fall.
- Triggers while busy are ignored (no queuing).
- arm_i low in any non-IDLE state: on the next edge glitch_o<=0, busy_o<=0, state=IDLE, no done_o.
- arm_i low in IDLE: rise is discarded, but the edge register still tracks, so a trigger already high at re-arm does not fire.
- Async rst mid-pulse forces glitch_o low immediately.
- Counters never wrap: D=65535, W=255, N=255 and S=65535 are all legal and exact.

Decomposition:
- Shared package glitcher_pkg holds:
  - state encoding localparams (IDLE/DELAY/PULSE/GAP);
  - config field widths (DELAY_W=16, WIDTH_W=8, NPULSE_W=8, SPACING_W=16), also used by uart_handler.
- One natural sub-module: sync_rise_detect (synchronizer plus rising-edge detector, parameterized by SYNC_STAGES), reusable for other external inputs.

Test Plan:
- SYNC_STAGES=2, arm=1, D=10, W=3, N=2, S=5, trigger high at edge 100:
  - glitch_o high after edges 112–114 and 120–122, low otherwise;
  - done_o high only after edge 123;
  - busy_o high from edge 102 through 122.
- D=0, W=1, N=1, trigger at edge 50 -> single 1-cycle glitch_o after edge 52; done_o after edge 53.
- W=0 or N=0, trigger -> glitch_o never high, busy_o never high, done_o strobed once after edge E0+2.
- D=20, W=4, N=3, S=0, trigger; then change width_i to 9 and pulse trigger again during DELAY -> three 4-cycle pulses separated by 1 low cycle; the second trigger is ignored.
- D=5, W=50, N=1, deassert arm_i after 10 high cycles -> glitch_o low on the next edge, busy_o low, no done_o; trigger held high while re-arming -> no new sequence.
- Assert rst asynchronously mid-pulse -> glitch_o and busy_o drop without waiting for a clk edge; after release, a fresh trigger produces a correct sequence.

Source files
------------

// File: rtl/glitcher_pkg.sv
// Shared definitions for the glitcher: sequencer state encoding, configuration
// field widths (also used by the UART command handler) and counter-load helpers.
package glitcher_pkg;

    localparam int DELAY_W   = 16;
    localparam int WIDTH_W   = 8;
    localparam int NPULSE_W  = 8;
    localparam int SPACING_W = 16;

    // The shared down-counter must hold the widest of delay, width and spacing.
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Counter load for a pulse of w high cycles (w is known to be non-zero).
    function automatic logic [CNT_W-1:0] width_load(input logic [WIDTH_W-1:0] w);
        return CNT_W'(w) - CNT_W'(1);
    endfunction

    // Counter load for a gap of s low cycles; s=0 is stretched to one cycle.
    function automatic logic [CNT_W-1:0] gap_load(input logic [SPACING_W-1:0] s);
        return (s == '0) ? '0 : CNT_W'(s) - CNT_W'(1);
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Multi-flop synchronizer for an asynchronous input followed by a one-cycle
// rising-edge detector. Reusable for any external level input.
module sync_rise_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the input through the synchronizer and remember the last synced level.
    // NOTE: non-blocking assignments make every flop sample the pre-edge value, so the chain really is SYNC_STAGES deep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/glitch_sequencer.sv
// Glitch timing engine: on an armed trigger rising edge it waits the programmed
// delay, then emits num_pulses pulses of programmed width separated by the
// programmed spacing. Configuration is snapshotted when a trigger is accepted.
module glitch_sequencer
    import glitcher_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trigger_i,
    input  logic                 arm_i,
    input  logic [DELAY_W-1:0]   delay_i,
    input  logic [WIDTH_W-1:0]   width_i,
    input  logic [NPULSE_W-1:0]  num_pulses_i,
    input  logic [SPACING_W-1:0] pulse_spacing_i,
    output logic                 glitch_o,
    output logic                 busy_o,
    output logic                 done_o
);

    logic w_rise;

    state_t               r_state,       w_state_next;
    logic [CNT_W-1:0]     r_cnt,         w_cnt_next;
    logic [NPULSE_W-1:0]  r_pulses_left, w_pulses_next;
    logic [WIDTH_W-1:0]   r_width,       w_width_next;
    logic [CNT_W-1:0]     r_gap_load,    w_gap_load_next;
    logic                 w_done_next;
    logic                 r_glitch, r_busy, r_done;

    sync_rise_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_trig_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (trigger_i),
        .o_rise  (w_rise)
    );

    // Next-state and datapath decisions; outputs follow directly from the next state.
    // NOTE: every signal gets its hold value first so no path through the case can infer a latch.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_pulses_next   = r_pulses_left;
        w_width_next    = r_width;
        w_gap_load_next = r_gap_load;
        w_done_next     = 1'b0;

        if (!arm_i) begin
            // Disarmed: drop any running sequence and discard triggers.
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        if (width_i == '0 || num_pulses_i == '0) begin
                            // Empty sequence completes on the acceptance edge.
                            w_done_next = 1'b1;
                        end else begin
                            w_width_next    = width_i;
                            w_gap_load_next = gap_load(pulse_spacing_i);
                            w_pulses_next   = num_pulses_i - NPULSE_W'(1);
                            if (delay_i == '0) begin
                                w_state_next = PULSE;
                                w_cnt_next   = width_load(width_i);
                            end else begin
                                w_state_next = DELAY;
                                w_cnt_next   = delay_i - DELAY_W'(1);
                            end
                        end
                    end
                end
                DELAY, GAP: begin
                    if (r_cnt == '0) begin
                        w_state_next = PULSE;
                        w_cnt_next   = width_load(r_width);
                    end else begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end
                PULSE: begin
                    if (r_cnt != '0) begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end else if (r_pulses_left != '0) begin
                        w_state_next  = GAP;
                        w_cnt_next    = r_gap_load;
                        w_pulses_next = r_pulses_left - NPULSE_W'(1);
                    end else begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // State, counters, snapshot and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_pulses_left <= '0;
            r_width       <= '0;
            r_gap_load    <= '0;
            r_glitch      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_pulses_left <= w_pulses_next;
            r_width       <= w_width_next;
            r_gap_load    <= w_gap_load_next;
            r_glitch      <= (w_state_next == PULSE);
            r_busy        <= (w_state_next != IDLE);
            r_done        <= w_done_next;
        end
    end

    assign glitch_o = r_glitch;
    assign busy_o   = r_busy;
    assign done_o   = r_done;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Self-checking bench for glitch_sequencer: table-driven sequences, hand-written
// corner cases (retrigger, abort/re-arm, async reset) and randomized configs,
// all compared cycle by cycle against a waveform model derived from the timing rules.
module tb_glitch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        trigger_i;
    logic        arm_i;
    logic [15:0] delay_i;
    logic [7:0]  width_i;
    logic [7:0]  num_pulses_i;
    logic [15:0] pulse_spacing_i;
    logic        glitch_o;
    logic        busy_o;
    logic        done_o;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    glitch_sequencer #(.SYNC_STAGES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .trigger_i       (trigger_i),
        .arm_i           (arm_i),
        .delay_i         (delay_i),
        .width_i         (width_i),
        .num_pulses_i    (num_pulses_i),
        .pulse_spacing_i (pulse_spacing_i),
        .glitch_o        (glitch_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int d, w, n, s;
        int exp_high;      // total glitch_o high cycles
        int exp_done_off;  // edge offset from E0 of the done strobe
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected {glitch, busy, done} after edge E0+t, from the timing rules.
    function automatic logic [2:0] model(input int t, input int d, input int w,
                                         input int n, input int s, input int abort_t);
        int  sm, start, fin;
        logic g, b, dn;
        if (abort_t >= 0 && t > abort_t) return 3'b000;
        if (w == 0 || n == 0) return {2'b00, (t == 2)};
        sm    = (s == 0) ? 1 : s;
        start = 2 + d;
        fin   = start + n * w + (n - 1) * sm;
        g  = (t >= start) && (t < fin) && (((t - start) % (w + sm)) < w);
        b  = (t >= 2) && (t < fin);
        dn = (t == fin);
        return {g, b, dn};
    endfunction

    // action: 0 none, 1 retrigger+width change in DELAY, 2 scramble config, 3 abort and re-arm
    task automatic run_seq(input int d, input int w, input int n, input int s,
                           input int len, input int action, input int abort_t,
                           output int high_cnt, output int done_off,
                           output int done_cnt, output int mism);
        int e0, t;
        logic [2:0] exp_v, act_v;
        delay_i         = 16'(d);
        width_i         = 8'(w);
        num_pulses_i    = 8'(n);
        pulse_spacing_i = 16'(s);
        @(negedge clk);
        trigger_i = 1'b1;
        e0 = edge_cnt + 1;
        high_cnt = 0; done_off = -1; done_cnt = 0; mism = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            t = edge_cnt - e0;
            exp_v = model(t, d, w, n, s, abort_t);
            act_v = {glitch_o, busy_o, done_o};
            if (act_v !== exp_v) mism++;
            if (glitch_o) high_cnt++;
            if (done_o) begin
                done_cnt++;
                if (done_off < 0) done_off = t;
            end
            if (action == 1) begin
                if (t == 8) begin trigger_i = 1'b0; width_i = 8'd9; end
                if (t == 12) trigger_i = 1'b1;
            end else if (action == 2 && t >= 2) begin
                delay_i         = 16'($urandom);
                width_i         = 8'($urandom);
                num_pulses_i    = 8'($urandom);
                pulse_spacing_i = 16'($urandom);
            end else if (action == 3) begin
                if (t == abort_t)      arm_i = 1'b0;
                if (t == abort_t + 14) arm_i = 1'b1;
            end
        end
        trigger_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int hc, doff, dcnt, mm, len;
        int d, w, n, s, sm;

        vecs[0] = '{10, 3,   2,   5,    6,   23};
        vecs[1] = '{0,  1,   1,   0,    1,   3};
        vecs[2] = '{7,  0,   3,   2,    0,   2};
        vecs[3] = '{7,  4,   0,   2,    0,   2};
        vecs[4] = '{20, 4,   3,   0,    12,  36};
        vecs[5] = '{0,  255, 2,   3,    510, 515};
        vecs[6] = '{1,  1,   255, 1,    255, 512};
        vecs[7] = '{300, 2,  2,   1000, 4,   1306};
        vecs[8] = '{5,  2,   3,   1,    6,   15};

        rst = 1'b1; trigger_i = 1'b0; arm_i = 1'b1;
        delay_i = '0; width_i = '0; num_pulses_i = '0; pulse_spacing_i = '0;
        repeat (3) @(negedge clk);
        check("reset_glitch", int'(glitch_o), 0);
        check("reset_busy",   int'(busy_o),   0);
        check("reset_done",   int'(done_o),   0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Table-driven sequences; trigger held high throughout must not retrigger.
        foreach (vecs[i]) begin
            run_seq(vecs[i].d, vecs[i].w, vecs[i].n, vecs[i].s,
                    vecs[i].exp_done_off + 4, 0, -1, hc, doff, dcnt, mm);
            check($sformatf("vec%0d_wave", i),     mm,   0);
            check($sformatf("vec%0d_high", i),     hc,   vecs[i].exp_high);
            check($sformatf("vec%0d_done_at", i),  doff, vecs[i].exp_done_off);
            check($sformatf("vec%0d_done_cnt", i), dcnt, 1);
        end

        // Second trigger and width change during DELAY are ignored.
        run_seq(20, 4, 3, 0, 40, 1, -1, hc, doff, dcnt, mm);
        check("retrig_wave",    mm,   0);
        check("retrig_high",    hc,   12);
        check("retrig_done_at", doff, 36);
        check("retrig_done_cnt", dcnt, 1);

        // Disarm after 10 high cycles, then re-arm with trigger still high.
        run_seq(5, 50, 1, 0, 80, 3, 16, hc, doff, dcnt, mm);
        check("abort_wave",     mm,   0);
        check("abort_high",     hc,   10);
        check("abort_done_cnt", dcnt, 0);

        // Async reset in the middle of a pulse.
        delay_i = 16'd2; width_i = 8'd20; num_pulses_i = 8'd1; pulse_spacing_i = 16'd0;
        @(negedge clk);
        trigger_i = 1'b1;
        repeat (8) @(negedge clk);
        check("pre_rst_glitch", int'(glitch_o), 1);
        #2;
        rst = 1'b1;
        trigger_i = 1'b0;
        #1;
        check("async_rst_glitch", int'(glitch_o), 0);
        check("async_rst_busy",   int'(busy_o),   0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_seq(vecs[0].d, vecs[0].w, vecs[0].n, vecs[0].s,
                vecs[0].exp_done_off + 4, 0, -1, hc, doff, dcnt, mm);
        check("post_rst_wave",    mm,   0);
        check("post_rst_done_at", doff, vecs[0].exp_done_off);

        // Randomized configurations with inputs scrambled mid-sequence.
        for (int k = 0; k < 12; k++) begin
            d = int'($urandom_range(0, 30));
            w = int'($urandom_range(0, 6));
            n = int'($urandom_range(0, 4));
            s = int'($urandom_range(0, 5));
            sm = (s == 0) ? 1 : s;
            len = (w == 0 || n == 0) ? 8 : 2 + d + n * w + (n - 1) * sm + 6;
            run_seq(d, w, n, s, len, 2, -1, hc, doff, dcnt, mm);
            check($sformatf("rand%0d_wave d=%0d w=%0d n=%0d s=%0d", k, d, w, n, s), mm, 0);
            check($sformatf("rand%0d_done_cnt", k), dcnt, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
